// File: rtl/rca_slice_sequencer.sv
// Slice sequencer for wide ripple-carry additions: LSB-first slices, chained carry, one registered output stage.
// Optional ADD_SUB_EN macro adds a per-operand 'sub' input selecting a - b.
module rca_slice_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_SLICES = 4,
  localparam int IDX_W = $clog2(MAX_SLICES)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ADD_SUB_EN
  input  logic                  sub,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  out_cout,
  output logic                  out_last,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  carry_q, carry_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  accept;
  logic                  sub_eff;
  logic                  cin_p0;
  logic                  forced_p0;
  logic [DATA_WIDTH-1:0] b_eff_p0;
  logic [DATA_WIDTH:0]   add_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] sum_p1;
  logic                  cout_p1;
  logic                  last_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic                  err_p1;

  function automatic logic [DATA_WIDTH:0] slice_add(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y,
                                                    input logic                  ci);
    return {1'b0, x} + {1'b0, y} + {{DATA_WIDTH{1'b0}}, ci};
  endfunction

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ADD_SUB_EN
  logic sub_q;
  // The operation is chosen on slice 0 and held for the rest of the operand.
  always_ff @(posedge clk) begin
    if (reset)                       sub_q <= 1'b0;
    else if (accept && state_q == IDLE) sub_q <= sub;
  end
  assign sub_eff = (state_q == IDLE) ? sub : sub_q;
`else
  assign sub_eff = 1'b0;
`endif

  // Stage p0: slice arithmetic and sequencing decisions
  assign cin_p0    = (state_q == IDLE) ? sub_eff : carry_q;
  assign b_eff_p0  = sub_eff ? ~b : b;
  assign add_p0    = slice_add(a, b_eff_p0, cin_p0);
  assign forced_p0 = (state_q == BUSY) && !in_last && (cnt_q == IDX_W'(MAX_SLICES - 1));

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (in_last || forced_p0) begin
        state_d = IDLE;
        carry_d = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        carry_d = add_p0[DATA_WIDTH];
        cnt_d   = cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p1: output register, overwritten on accept even while draining
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      last_p1 <= 1'b0;
      idx_p1  <= '0;
      err_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      sum_p1  <= add_p0[DATA_WIDTH-1:0];
      cout_p1 <= add_p0[DATA_WIDTH];
      last_p1 <= in_last || forced_p0;
      idx_p1  <= cnt_q;
      err_p1  <= forced_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign out_cout  = cout_p1;
  assign out_last  = last_p1;
  assign out_idx   = idx_p1;
  assign out_err   = err_p1;

endmodule

// File: doc/rca_slice_sequencer.md
Name: rca_slice_sequencer

Overview:
- Upstream/downstream companion to the ripple carry adder. Streams operands wider than DATA_WIDTH as a sequence of DATA_WIDTH slices, LSB slice first.
- Each slice is added with a registered carry chained from the previous slice, so a DATA_WIDTH RCA datapath can serve arbitrarily wide additions.
- Valid/ready handshake on both sides; one registered output stage.

Parameters:
DATA_WIDTH, 8, width of one operand slice and of the per-slice sum
MAX_SLICES, 4, maximum number of slices per operand (>=2); IDX_W = $clog2(MAX_SLICES)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  slice present on a/b/in_last
in_ready  output  1  block accepts slice this cycle
a  input  DATA_WIDTH  operand A slice
b  input  DATA_WIDTH  operand B slice
in_last  input  1  slice is the MSB slice of the operand
out_valid  output  1  result slice valid
out_ready  input  1  consumer accepts result slice
sum  output  DATA_WIDTH  result slice
out_cout  output  1  carry out of this slice (final carry when out_last=1)
out_last  output  1  result slice is the last of the operand
out_idx  output  IDX_W  slice index of result within its operand (0 = LSB)
out_err  output  1  operand exceeded MAX_SLICES; forced termination

Behaviour:
- Reset: out_valid=0, sum=0, out_cout=0, out_last=0, out_idx=0, out_err=0, carry register=0, slice counter=0, state=IDLE. Reset takes effect mid-operand: the partial operand and any pending output are discarded.
- in_ready = !out_valid || out_ready. This is combinational; the block allows full throughput of one slice per cycle.
- Accept: in_valid && in_ready.
- Per-slice arithmetic: {c, s} = a + b + carry_reg, (DATA_WIDTH+1)-bit result.
- Latency: a slice accepted in cycle N is presented in cycle N+1. The registered values are:
  - sum <= s
  - out_cout <= c
  - out_idx <= slice counter
  - out_last <= in_last || forced
  - out_err <= forced
- Output hold: out_valid stays 1 and all outputs hold stable until out_ready=1. If out_ready=1 and there is no accept, out_valid falls to 0.
- State machine:
  - IDLE: no partial operand; carry_reg=0, counter=0. Accept with in_last=1 stays IDLE. Accept with in_last=0 goes to BUSY, carry_reg<=c, counter<=1.
  - BUSY: partial operand in progress. Accept with in_last=0 and counter<MAX_SLICES-1 stays BUSY, carry_reg<=c, counter++. Accept with in_last=1 goes to IDLE.
- Overlength: accepting a slice in BUSY with counter==MAX_SLICES-1 and in_last=0 sets forced=1. That beat gets out_last=1 and out_err=1, then the block returns to IDLE.
- Any transition to IDLE clears carry_reg and counter. The final carry is never propagated into the next operand.
- Simultaneous output drain and new accept in the same cycle: the output register is overwritten with the new slice and out_valid stays 1; no bubble.
- Inputs are ignored when in_valid=0. A/b values outside an accept cycle have no effect.

Optional Feature:
- Macro ADD_SUB_EN.
- Defined: extra input port sub (1 bit), sampled only on the first slice of an operand (state IDLE) and latched for the whole operand.
  - When latched sub=1, each slice computes a + ~b + carry_reg, and carry_reg starts at 1 for slice 0. Result is the two's-complement a-b; final out_cout=1 means no borrow.
  - sub presented on later slices is ignored.
- Undefined: port sub is absent; addition only.

Test Plan:
- Single slice: a=0xFF, b=0x01, in_last=1, out_ready=1 -> next cycle sum=0x00, out_cout=1, out_last=1, out_idx=0, out_err=0.
- 16-bit operand 0x00FF+0x0001: slice0 gives sum=0x00, cout=1, idx=0; slice1 gives sum=0x01, cout=0, last=1, idx=1. Back-to-back, in_ready held 1.
- Backpressure: hold out_ready=0 after the first result -> in_ready=0, and sum/out_idx stay stable for 5 cycles. Releasing out_ready with in_valid=1 gives drain and accept in the same cycle, with no bubble.
- Carry isolation: operand 0xFF+0x01 (last, cout=1) followed by operand 0x01+0x01 -> second sum=0x02, not 0x03.
- Overlength (MAX_SLICES=4): four slices 0x00+0x00 with in_last=0 -> fourth result has out_idx=3, out_last=1, out_err=1. The next slice reports out_idx=0.
- Reset mid-operand: slice 0xFF+0x01 with in_last=0, then reset pulse -> out_valid=0. A new slice 0x00+0x00 with last=1 gives sum=0x00, cout=0, idx=0.
- (ADD_SUB_EN) sub=1, a=0x05, b=0x07, last=1 -> sum=0xFE, out_cout=0.
